// File: rtl/dht11_fmt_pkg.sv
// Shared types and constants for the DHT11 ASCII line formatter.
// Optional checksum field is enabled by DHT11_FMT_CHECKSUM_EN in the top.
package dht11_fmt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      SEND = 2'd2
   } state_t;

   localparam logic [7:0] ASC_H    = 8'h48;
   localparam logic [7:0] ASC_T    = 8'h54;
   localparam logic [7:0] ASC_EQ   = 8'h3D;
   localparam logic [7:0] ASC_PCT  = 8'h25;
   localparam logic [7:0] ASC_SP   = 8'h20;
   localparam logic [7:0] ASC_STAR = 8'h2A;
   localparam logic [7:0] ASC_CR   = 8'h0D;
   localparam logic [7:0] ASC_LF   = 8'h0A;
   localparam logic [7:0] ASC_0    = 8'h30;

   localparam int CONV_CYCLES = 10;

   // Lengths include the CR; the top drops one byte when the CR is not wanted.
   localparam int MSG_LEN_BASE  = 13;
   localparam int MSG_LEN_CKSUM = 17;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10) return ASC_0 + {4'h0, nib};
      else             return 8'h37 + {4'h0, nib};
   endfunction

endpackage

// File: rtl/bin2bcd2_seq.sv
// Sequential 8-bit to two-digit BCD by repeated subtraction of ten.
// Values above 99 saturate to "99".
module bin2bcd2_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] value,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   logic [7:0] rem;
   logic [3:0] tens_q;
   logic       sat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem    <= 8'd0;
         tens_q <= 4'd0;
         sat    <= 1'b0;
      end else if (load) begin
         rem    <= value;
         tens_q <= 4'd0;
         sat    <= (value > 8'd99);
      end else if (!sat && rem >= 8'd10) begin
         rem <= rem - 8'd10;
         if (tens_q != 4'd9) tens_q <= tens_q + 4'd1;
      end
   end

   assign tens = sat ? 4'd9 : tens_q;
   assign ones = sat ? 4'd9 : rem[3:0];

endmodule

// File: rtl/dht11_ascii_formatter.sv
// Formats one DHT11 reading as "H=hh% T=ttU[ *cc]\r\n" and pushes it into the TX FIFO.
// Define DHT11_FMT_CHECKSUM_EN to append the " *cc" hex checksum field.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after a line
// CONV  | fixed 10-cycle binary-to-BCD conversion of both readings
// SEND  | pushing message bytes, stalling while fifo_full
module dht11_ascii_formatter
   import dht11_fmt_pkg::*;
#(
   parameter int         EOL_CR    = 1,
   parameter logic [7:0] TEMP_UNIT = 8'h43
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] humidity,
   input  logic [7:0] temperature,
   input  logic       fifo_full,
   output logic [7:0] ascii_out,
   output logic       push_out,
   output logic       busy,
   output logic       done
);

`ifdef DHT11_FMT_CHECKSUM_EN
   localparam int FULL_LEN = MSG_LEN_CKSUM;
`else
   localparam int FULL_LEN = MSG_LEN_BASE;
`endif
   localparam int MSG_LEN = FULL_LEN - ((EOL_CR != 0) ? 0 : 1);

   state_t      state_q, state_nxt;
   logic [3:0]  cnt_q, cnt_nxt;
   logic [4:0]  idx_q, idx_nxt;
   logic        done_q, done_nxt;
   logic        accept;
   logic [3:0]  h_tens, h_ones, t_tens, t_ones;
   logic [7:0]  msg_byte;

   assign accept   = (state_q == IDLE) && start;
   assign push_out = (state_q == SEND) && !fifo_full;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;

   bin2bcd2_seq u_hum (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .value (humidity),
      .tens  (h_tens),
      .ones  (h_ones)
   );

   bin2bcd2_seq u_temp (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .value (temperature),
      .tens  (t_tens),
      .ones  (t_ones)
   );

`ifdef DHT11_FMT_CHECKSUM_EN
   // Checksum uses the raw readings, not the saturated digits.
   logic [7:0] cks_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        cks_q <= 8'd0;
      else if (accept) cks_q <= humidity + temperature;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= 5'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         idx_q   <= idx_nxt;
         done_q  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      idx_nxt   = idx_q;
      done_nxt  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_nxt = CONV;
               cnt_nxt   = 4'(CONV_CYCLES - 1);
               idx_nxt   = 5'd0;
            end
         end
         CONV: begin
            if (cnt_q == 4'd0) state_nxt = SEND;
            else               cnt_nxt   = cnt_q - 4'd1;
         end
         SEND: begin
            if (push_out) begin
               if (idx_q == 5'(MSG_LEN - 1)) begin
                  state_nxt = IDLE;
                  idx_nxt   = 5'd0;
                  done_nxt  = 1'b1;
               end else begin
                  idx_nxt = idx_q + 5'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      msg_byte = 8'h00;
      case (idx_q)
         5'd0:  msg_byte = ASC_H;
         5'd1:  msg_byte = ASC_EQ;
         5'd2:  msg_byte = ASC_0 + {4'h0, h_tens};
         5'd3:  msg_byte = ASC_0 + {4'h0, h_ones};
         5'd4:  msg_byte = ASC_PCT;
         5'd5:  msg_byte = ASC_SP;
         5'd6:  msg_byte = ASC_T;
         5'd7:  msg_byte = ASC_EQ;
         5'd8:  msg_byte = ASC_0 + {4'h0, t_tens};
         5'd9:  msg_byte = ASC_0 + {4'h0, t_ones};
         5'd10: msg_byte = TEMP_UNIT;
`ifdef DHT11_FMT_CHECKSUM_EN
         5'd11: msg_byte = ASC_SP;
         5'd12: msg_byte = ASC_STAR;
         5'd13: msg_byte = hex_ascii(cks_q[7:4]);
         5'd14: msg_byte = hex_ascii(cks_q[3:0]);
`endif
         default: ;
      endcase
      // End-of-line bytes sit at the tail so their position follows EOL_CR.
      if (idx_q == 5'(MSG_LEN - 1))                      msg_byte = ASC_LF;
      else if ((EOL_CR != 0) && idx_q == 5'(MSG_LEN - 2)) msg_byte = ASC_CR;
   end

   assign ascii_out = push_out ? msg_byte : 8'h00;

endmodule

// File: tb/tb_dht11_ascii_formatter.sv
// Directed bench for dht11_ascii_formatter: vector table of readings plus
// hand sequences for backpressure, ignored/back-to-back start and mid-line reset.
module tb_dht11_ascii_formatter;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] humidity;
   logic [7:0] temperature;
   logic       fifo_full;
   logic [7:0] ascii_out;
   logic       push_out;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dht11_ascii_formatter #(
      .EOL_CR    (1),
      .TEMP_UNIT (8'h43)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .humidity    (humidity),
      .temperature (temperature),
      .fifo_full   (fifo_full),
      .ascii_out   (ascii_out),
      .push_out    (push_out),
      .busy        (busy),
      .done        (done)
   );

   typedef struct {
      logic [7:0] h;
      logic [7:0] t;
      string      body;
      string      cks;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         chk({tag, " post_idle"}, int'({push_out, busy, done}), 0);
      end
   endtask

   // Sends one line and checks every pushed byte, busy, and done timing.
   // Relative cycle 0 is the edge that accepts start.
   task automatic run_line(input logic [7:0] h, input logic [7:0] t,
                           input string body, input string cks,
                           input bit skip_start, input int flo, input int fhi,
                           input int ign_rel, input int extra,
                           input bit chain, input logic [7:0] ch, input logic [7:0] ct,
                           input string tag);
      logic [7:0] exp_q[$];
      int k = 0;
      int first_rel = -1;
      int done_rel = -1;
      int exp_done;
      for (int i = 0; i < body.len(); i++) exp_q.push_back(body[i]);
`ifdef DHT11_FMT_CHECKSUM_EN
      exp_q.push_back(8'h20);
      exp_q.push_back(8'h2A);
      exp_q.push_back(cks[0]);
      exp_q.push_back(cks[1]);
`endif
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      exp_done = 11 + exp_q.size() + extra;

      if (!skip_start) begin
         @(negedge clk);
         humidity    = h;
         temperature = t;
         start       = 1'b1;
      end
      for (int rel = 1; rel <= 80 && done_rel < 0; rel++) begin
         @(negedge clk);
         start = 1'b0;
         if (rel == 2) begin
            humidity    = 8'd11;
            temperature = 8'd22;
         end
         if (rel == ign_rel) begin
            start       = 1'b1;
            humidity    = 8'd77;
            temperature = 8'd88;
         end
         fifo_full = (rel >= flo && rel <= fhi);
         #1;
         if (push_out) begin
            if (first_rel < 0) first_rel = rel;
            if (fifo_full) chk({tag, " push_while_full"}, 1, 0);
            if (k < exp_q.size())
               chk({tag, $sformatf(" byte%0d", k)}, int'(ascii_out), int'(exp_q[k]));
            else
               chk({tag, " extra_byte"}, k, exp_q.size());
            k++;
         end else begin
            chk({tag, " idle_byte"}, int'(ascii_out), 0);
         end
         if (done) begin
            done_rel = rel;
            chk({tag, " busy_at_done"}, int'(busy), 0);
         end else begin
            chk({tag, " busy"}, int'(busy), 1);
         end
      end
      chk({tag, " first_push_cycle"}, first_rel, 11);
      chk({tag, " byte_count"}, k, exp_q.size());
      chk({tag, " done_cycle"}, done_rel, exp_done);
      fifo_full = 1'b0;
      if (chain) begin
         humidity    = ch;
         temperature = ct;
         start       = 1'b1;
      end else begin
         idle_cycles(14, tag);
      end
   endtask

   initial begin
      vecs[0] = '{8'd45,  8'd23,  "H=45% T=23C", "44"};
      vecs[1] = '{8'd150, 8'd5,   "H=99% T=05C", "9B"};
      vecs[2] = '{8'd0,   8'd0,   "H=00% T=00C", "00"};
      vecs[3] = '{8'd99,  8'd100, "H=99% T=99C", "C7"};
      vecs[4] = '{8'd10,  8'd9,   "H=10% T=09C", "13"};
      vecs[5] = '{8'd255, 8'd255, "H=99% T=99C", "FE"};
      vecs[6] = '{8'd200, 8'd100, "H=99% T=99C", "2C"};

      rst         = 1'b0;
      start       = 1'b0;
      humidity    = 8'd0;
      temperature = 8'd0;
      fifo_full   = 1'b0;
      #1;
      chk("reset_outputs", int'({ascii_out, push_out, busy, done}), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle_cycles(3, "after_reset");

      for (int i = 0; i < 7; i++)
         run_line(vecs[i].h, vecs[i].t, vecs[i].body, vecs[i].cks,
                  1'b0, 0, -1, -1, 0, 1'b0, 8'd0, 8'd0, $sformatf("vec%0d", i));

      // Backpressure during cycles 13-16.
      run_line(8'd45, 8'd23, "H=45% T=23C", "44", 1'b0, 13, 16, -1, 4,
               1'b0, 8'd0, 8'd0, "backpressure");

      // start while busy is ignored and not queued.
      run_line(8'd45, 8'd23, "H=45% T=23C", "44", 1'b0, 0, -1, 5, 0,
               1'b0, 8'd0, 8'd0, "ignored_start");

      // start in the done cycle begins the next line.
      run_line(8'd45, 8'd23, "H=45% T=23C", "44", 1'b0, 0, -1, -1, 0,
               1'b1, 8'd10, 8'd9, "b2b_first");
      run_line(8'd10, 8'd9, "H=10% T=09C", "13", 1'b1, 0, -1, -1, 0,
               1'b0, 8'd0, 8'd0, "b2b_second");

      // Reset in the middle of SEND.
      @(negedge clk);
      humidity    = 8'd45;
      temperature = 8'd23;
      start       = 1'b1;
      for (int rel = 1; rel <= 15; rel++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1;
      chk("pre_reset_push", int'(push_out), 1);
      rst = 1'b0;
      #1;
      chk("reset_push", int'(push_out), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_ascii", int'(ascii_out), 0);
      chk("reset_done", int'(done), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle_cycles(14, "reset_release");
      run_line(8'd150, 8'd5, "H=99% T=05C", "9B", 1'b0, 0, -1, -1, 0,
               1'b0, 8'd0, 8'd0, "after_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
